// File: rtl/screen_color_scheduler_pkg.sv
// Shared types for the frame-synchronous colour scheduler and its command FIFO.
package screen_sched_pkg;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    typedef struct packed {
        rgb444_t    color;
        logic [7:0] frames;
    } color_cmd_t;

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } sched_state_t;

    // A zero frame count still shows the colour for one frame.
    function automatic logic [7:0] hold_frames(input logic [7:0] frames);
        return (frames == 8'd0) ? 8'd1 : frames;
    endfunction

endpackage

// File: rtl/color_cmd_fifo.sv
// First-word-fall-through command FIFO; flush and reset both empty it.
module color_cmd_fifo
    import screen_sched_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk_25,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  color_cmd_t               din,
    output color_cmd_t               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LEVEL_ONE  = (AW + 1)'(1);
    localparam logic [AW:0] LEVEL_FULL = (AW + 1)'(DEPTH);

    color_cmd_t     mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign full    = (level == LEVEL_FULL);
    assign empty   = (level == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk_25) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk_25) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                level <= level + LEVEL_ONE;
            end else if (!do_push && do_pop) begin
                level <= level - LEVEL_ONE;
            end
        end
    end

endmodule

// File: rtl/screen_color_scheduler.sv
// Applies queued RGB444 colours only on vertical-sync assertion and holds each
// for its programmed number of frames.
module screen_color_scheduler
    import screen_sched_pkg::*;
#(
    parameter int         DEPTH     = 8,
    parameter logic       VSYNC_ACT = 1'b0,
    parameter logic [3:0] DEF_RED   = 4'h0,
    parameter logic [3:0] DEF_GREEN = 4'h0,
    parameter logic [3:0] DEF_BLUE  = 4'h0
) (
    input  logic                     clk_25,
    input  logic                     reset,
    input  logic                     v_sync,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [3:0]               cmd_red,
    input  logic [3:0]               cmd_green,
    input  logic [3:0]               cmd_blue,
    input  logic [7:0]               cmd_frames,
    input  logic                     flush,
    output logic [3:0]               Red_level,
    output logic [3:0]               Green_level,
    output logic [3:0]               Blue_level,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [15:0]              frame_count
);

    localparam rgb444_t DEF_COLOR = '{r: DEF_RED, g: DEF_GREEN, b: DEF_BLUE};

    sched_state_t state, state_n;
    logic [7:0]   hold, hold_n;
    rgb444_t      color_q, color_n;
    color_cmd_t   din, head;
    logic         v_sync_d;
    logic         tick;
    logic         full, empty;
    logic         push, pop;

    assign tick      = (v_sync == VSYNC_ACT) && (v_sync_d != VSYNC_ACT);
    assign cmd_ready = !full && !flush && !reset;
    assign push      = cmd_valid && cmd_ready;
    assign din       = '{color: '{r: cmd_red, g: cmd_green, b: cmd_blue}, frames: cmd_frames};

    assign Red_level   = color_q.r;
    assign Green_level = color_q.g;
    assign Blue_level  = color_q.b;
    assign busy        = (state == SHOW);

    color_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_25 (clk_25),
        .reset  (reset),
        .flush  (flush),
        .push   (push),
        .pop    (pop),
        .din    (din),
        .dout   (head),
        .full   (full),
        .empty  (empty),
        .level  (fifo_level)
    );

    // Flush wins over a tick, so no pop and no colour change can happen with it.
    always_comb begin
        state_n = state;
        hold_n  = hold;
        color_n = color_q;
        pop     = 1'b0;
        if (flush) begin
            state_n = IDLE;
            hold_n  = 8'd0;
        end else if (tick) begin
            if (state == SHOW && hold > 8'd1) begin
                hold_n = hold - 8'd1;
            end else if (!empty) begin
                pop     = 1'b1;
                color_n = head.color;
                hold_n  = hold_frames(head.frames);
                state_n = SHOW;
            end else begin
                hold_n  = 8'd0;
                state_n = IDLE;
            end
        end
    end

    always_ff @(posedge clk_25) begin
        if (reset) begin
            state       <= IDLE;
            hold        <= 8'd0;
            color_q     <= DEF_COLOR;
            v_sync_d    <= VSYNC_ACT;
            frame_count <= 16'd0;
        end else begin
            state    <= state_n;
            hold     <= hold_n;
            color_q  <= color_n;
            v_sync_d <= v_sync;
            if (tick) begin
                frame_count <= frame_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_screen_color_scheduler.sv
// Scoreboard bench: a frame-level reference model queues expected outputs each
// cycle and a monitor compares them against the scheduler.
module tb_screen_color_scheduler;
    import screen_sched_pkg::*;

    localparam int         DEPTH   = 8;
    localparam logic       VACT    = 1'b0;
    localparam logic       VINACT  = 1'b1;
    localparam logic [11:0] DEF_RGB = 12'h000;

    logic        clk_25 = 1'b0;
    logic        reset;
    logic        v_sync;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_red, cmd_green, cmd_blue;
    logic [7:0]  cmd_frames;
    logic        flush;
    logic [3:0]  Red_level, Green_level, Blue_level;
    logic        busy;
    logic [3:0]  fifo_level;
    logic [15:0] frame_count;

    int checks = 0;
    int errors = 0;

    screen_color_scheduler #(
        .DEPTH     (DEPTH),
        .VSYNC_ACT (VACT),
        .DEF_RED   (4'h0),
        .DEF_GREEN (4'h0),
        .DEF_BLUE  (4'h0)
    ) dut (
        .clk_25      (clk_25),
        .reset       (reset),
        .v_sync      (v_sync),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_red     (cmd_red),
        .cmd_green   (cmd_green),
        .cmd_blue    (cmd_blue),
        .cmd_frames  (cmd_frames),
        .flush       (flush),
        .Red_level   (Red_level),
        .Green_level (Green_level),
        .Blue_level  (Blue_level),
        .busy        (busy),
        .fifo_level  (fifo_level),
        .frame_count (frame_count)
    );

    always #5 clk_25 = ~clk_25;

    typedef struct packed {
        logic [11:0] rgb;
        logic        busy;
        logic [3:0]  level;
        logic [15:0] fc;
    } exp_t;

    typedef struct {
        logic [11:0] rgb;
        int          frames;
    } mcmd_t;

    exp_t        exp_q[$];
    mcmd_t       m_q[$];
    mcmd_t       m_head;
    mcmd_t       m_new;
    logic [11:0] m_rgb = DEF_RGB;
    int          m_left = 0;
    logic [15:0] m_fc = 16'd0;
    logic        m_prev = VACT;
    logic        m_tick;
    logic        m_ready;

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: one frame-level step per clock edge on the sampled inputs.
    always @(posedge clk_25) begin
        if (reset) begin
            m_q.delete();
            m_rgb  = DEF_RGB;
            m_left = 0;
            m_fc   = 16'd0;
            m_prev = VACT;
        end else begin
            m_tick  = (v_sync == VACT) && (m_prev != VACT);
            m_prev  = v_sync;
            m_ready = (m_q.size() < DEPTH) && !flush;
            if (flush) begin
                m_q.delete();
                m_left = 0;
            end else begin
                if (m_tick) begin
                    if (m_left > 1) begin
                        m_left--;
                    end else if (m_q.size() > 0) begin
                        m_head = m_q.pop_front();
                        m_rgb  = m_head.rgb;
                        m_left = (m_head.frames == 0) ? 1 : m_head.frames;
                    end else begin
                        m_left = 0;
                    end
                end
                if (cmd_valid && m_ready) begin
                    m_new.rgb    = {cmd_red, cmd_green, cmd_blue};
                    m_new.frames = int'(cmd_frames);
                    m_q.push_back(m_new);
                end
            end
            if (m_tick) m_fc = m_fc + 16'd1;
        end
        exp_q.push_back('{rgb: m_rgb, busy: (m_left > 0), level: 4'(m_q.size()), fc: m_fc});
    end

    // Monitor: the DUT presents a new output set after every clock edge.
    always @(posedge clk_25) begin
        exp_t e;
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard_empty at %0t: got 0 entries expected 1", $time);
        end else begin
            e = exp_q.pop_front();
            checkOutput("red",         16'(Red_level),   16'(e.rgb[11:8]));
            checkOutput("green",       16'(Green_level), 16'(e.rgb[7:4]));
            checkOutput("blue",        16'(Blue_level),  16'(e.rgb[3:0]));
            checkOutput("busy",        16'(busy),        16'(e.busy));
            checkOutput("fifo_level",  16'(fifo_level),  16'(e.level));
            checkOutput("frame_count", frame_count,      e.fc);
        end
    end

    always @(negedge clk_25) begin
        #1;
        checkOutput("cmd_ready", 16'(cmd_ready),
                    16'(!reset && !flush && (m_q.size() < DEPTH)));
    end

    task automatic applyStimulus(input logic rst, input logic vs, input logic valid,
                                 input logic [11:0] rgb, input logic [7:0] fr, input logic fl);
        @(negedge clk_25);
        reset      = rst;
        v_sync     = vs;
        cmd_valid  = valid;
        cmd_red    = rgb[11:8];
        cmd_green  = rgb[7:4];
        cmd_blue   = rgb[3:0];
        cmd_frames = fr;
        flush      = fl;
    endtask

    task automatic idleCycles(input int n, input logic vs);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, vs, 1'b0, 12'h000, 8'd0, 1'b0);
    endtask

    task automatic pushCmd(input logic [11:0] rgb, input logic [7:0] fr);
        applyStimulus(1'b0, VINACT, 1'b1, rgb, fr, 1'b0);
    endtask

    task automatic vsyncPulse(input int inactive);
        idleCycles(2, VACT);
        idleCycles(inactive, VINACT);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog at %0t: got timeout expected finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int period;
        int phase;
        logic vs;
        reset = 1'b1; v_sync = VINACT; cmd_valid = 1'b0; flush = 1'b0;
        cmd_red = 4'h0; cmd_green = 4'h0; cmd_blue = 4'h0; cmd_frames = 8'd0;
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, VINACT, 1'b0, 12'h000, 8'd0, 1'b0);
        idleCycles(3, VINACT);

        // Three empty frames: colour stays default, frame_count reaches 3.
        for (int i = 0; i < 3; i++) vsyncPulse(5);

        // Red for two frames, then green for one, then idle with green kept.
        pushCmd(12'hF00, 8'd2);
        pushCmd(12'h0F0, 8'd1);
        idleCycles(2, VINACT);
        for (int i = 0; i < 5; i++) vsyncPulse(5);

        // Zero frame count behaves as one frame.
        pushCmd(12'hA53, 8'd0);
        idleCycles(2, VINACT);
        for (int i = 0; i < 3; i++) vsyncPulse(5);

        // Hold cmd_valid high: eight accepted, the ninth after the next pop.
        for (int i = 0; i < 12; i++) applyStimulus(1'b0, VINACT, 1'b1, 12'h123, 8'd1, 1'b0);
        applyStimulus(1'b0, VACT, 1'b1, 12'h456, 8'd1, 1'b0);
        applyStimulus(1'b0, VACT, 1'b1, 12'h456, 8'd1, 1'b0);
        applyStimulus(1'b0, VINACT, 1'b1, 12'h456, 8'd1, 1'b0);
        idleCycles(4, VINACT);
        for (int i = 0; i < 4; i++) vsyncPulse(4);

        // Flush on a tick cycle with a push attempted alongside it.
        applyStimulus(1'b0, VACT, 1'b1, 12'h789, 8'd3, 1'b1);
        idleCycles(1, VACT);
        idleCycles(4, VINACT);
        for (int i = 0; i < 2; i++) vsyncPulse(4);

        // Reset mid-hold with v_sync held active through the release.
        pushCmd(12'h5AF, 8'd5);
        pushCmd(12'hC0C, 8'd2);
        idleCycles(2, VINACT);
        for (int i = 0; i < 2; i++) vsyncPulse(4);
        idleCycles(1, VACT);
        applyStimulus(1'b1, VACT, 1'b0, 12'h000, 8'd0, 1'b0);
        applyStimulus(1'b1, VACT, 1'b0, 12'h000, 8'd0, 1'b0);
        idleCycles(3, VACT);
        idleCycles(4, VINACT);
        vsyncPulse(4);

        // Randomised traffic over random frame lengths.
        period = 8;
        phase  = 0;
        for (int i = 0; i < 600; i++) begin
            vs = (phase < 2) ? VACT : VINACT;
            phase++;
            if (phase >= period) begin
                phase  = 0;
                period = $urandom_range(12, 5);
            end
            applyStimulus(1'b0, vs, ($urandom_range(99, 0) < 35),
                          12'($urandom), 8'($urandom_range(3, 0)),
                          ($urandom_range(99, 0) < 3));
        end
        idleCycles(3, VINACT);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
